// File: rtl/router_1xn_if.sv
// router_1xn bus: byte-stream source handshake plus per-port output FIFOs.
// Ports: pkt_valid/data_in/busy/error/drop (source), read_enb/valid_out/data_out/soft_reset (sinks).
interface router_1xn_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3
);
    logic                        pkt_valid;
    logic [DATA_W-1:0]           data_in;
    logic                        busy;
    logic                        error;
    logic                        drop;
    logic [NUM_PORTS-1:0]        read_enb;
    logic [NUM_PORTS-1:0]        valid_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [NUM_PORTS-1:0]        soft_reset;

    modport master (
        output pkt_valid, data_in, read_enb,
        input  busy, error, drop, valid_out, data_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, read_enb,
        output busy, error, drop, valid_out, data_out, soft_reset
    );
endinterface

// File: rtl/router_1xn.sv
// 1xN packet router: steers header/payload/parity packets into per-port FWFT FIFOs.
// Ports: clock, reset (sync, active-high), bus (router_1xn_if.slave).
module router_1xn #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic        clock,
    input  logic        reset,
    router_1xn_if.slave bus
);
    localparam int LEN_W = DATA_W - 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_EMPTY, LOAD, FULL, CHECK, DROP
    } state_t;

    state_t state, state_n;

    logic [1:0]        tgt;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] parity;
    logic [LEN_W-1:0]  cnt;
    logic              chk_bad;
    logic              bad_addr;
    logic              error_q;
    logic              drop_q;

    logic [DATA_W-1:0]    mem  [NUM_PORTS][FIFO_DEPTH];
    logic [AW:0]          wptr [NUM_PORTS];
    logic [AW:0]          rptr [NUM_PORTS];
    logic [TW-1:0]        tcnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] sr_q;

    // Padded to the full 2-bit address space so any
    // header address can index them; absent ports look empty.
    logic [3:0] fifo_empty;
    logic [3:0] fifo_full;
    logic [3:0] to_hit;

    logic [1:0]        addr;
    logic [1:0]        port;
    logic              addr_ok;
    logic              busy;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    assign addr    = bus.data_in[1:0];
    assign addr_ok = int'(addr) < NUM_PORTS;
    assign port    = (state == IDLE) ? addr : tgt;

    for (genvar i = 0; i < 4; i++) begin : g_flag
        if (i < NUM_PORTS) begin : g_real
            assign fifo_empty[i] = wptr[i] == rptr[i];
            assign fifo_full[i]  =
                (wptr[i][AW] != rptr[i][AW]) &&
                (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
            // Last stalled cycle before the flush.
            assign to_hit[i] = !fifo_empty[i] &&
                               !bus.read_enb[i] &&
                               tcnt[i] == TW'(TIMEOUT - 1);
            assign bus.valid_out[i] = !fifo_empty[i];
            assign bus.data_out[i*DATA_W +: DATA_W] =
                fifo_empty[i] ? '0 : mem[i][rptr[i][AW-1:0]];
        end else begin : g_pad
            assign fifo_empty[i] = 1'b1;
            assign fifo_full[i]  = 1'b0;
            assign to_hit[i]     = 1'b0;
        end
    end

    assign bus.busy       = busy;
    assign bus.error      = error_q;
    assign bus.drop       = drop_q;
    assign bus.soft_reset = sr_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    if (!addr_ok)               state_n = DROP;
                    else if (fifo_empty[addr])  state_n = LOAD;
                    else                        state_n = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (to_hit[tgt])           state_n = DROP;
                else if (fifo_empty[tgt])  state_n = LOAD;
            end
            LOAD: begin
                // A flushed target discards the rest; if the parity
                // byte was just taken the packet is already over.
                if (to_hit[tgt])
                    state_n = (bus.pkt_valid || fifo_full[tgt]) ? DROP : IDLE;
                else if (fifo_full[tgt])   state_n = FULL;
                else if (!bus.pkt_valid)   state_n = CHECK;
            end
            FULL: begin
                if (to_hit[tgt])           state_n = DROP;
                else if (!fifo_full[tgt])  state_n = LOAD;
            end
            CHECK:   state_n = IDLE;
            DROP:    if (!bus.pkt_valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        wr_en   = 1'b0;
        wr_data = bus.data_in;
        case (state)
            IDLE: wr_en = bus.pkt_valid && addr_ok && fifo_empty[addr];
            WAIT_EMPTY: begin
                busy    = 1'b1;
                wr_en   = fifo_empty[tgt];
                wr_data = hdr;
            end
            LOAD: begin
                busy  = fifo_full[tgt];
                wr_en = !fifo_full[tgt] && !to_hit[tgt];
            end
            FULL, CHECK: busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tgt      <= '0;
            hdr      <= '0;
            parity   <= '0;
            cnt      <= '0;
            chk_bad  <= 1'b0;
            bad_addr <= 1'b0;
            error_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        tgt      <= addr;
                        hdr      <= bus.data_in;
                        parity   <= bus.data_in;
                        cnt      <= '0;
                        error_q  <= 1'b0;
                        bad_addr <= !addr_ok;
                    end
                end
                LOAD: begin
                    if (!fifo_full[tgt]) begin
                        if (bus.pkt_valid) begin
                            parity <= parity ^ bus.data_in;
                            if (cnt != '1) cnt <= cnt + 1'b1;
                        end else begin
                            chk_bad <= (bus.data_in != parity) ||
                                       (cnt != hdr[DATA_W-1:2]);
                        end
                    end
                end
                CHECK: error_q <= chk_bad;
                DROP:  if (!bus.pkt_valid) drop_q <= bad_addr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_en && port == 2'(i))
                mem[i][wptr[i][AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                tcnt[i] <= '0;
            end
            sr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                sr_q[i] <= to_hit[i];
                if (to_hit[i]) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    tcnt[i] <= '0;
                end else begin
                    if (wr_en && port == 2'(i))
                        wptr[i] <= wptr[i] + 1'b1;
                    if (bus.read_enb[i] && !fifo_empty[i])
                        rptr[i] <= rptr[i] + 1'b1;
                    if (!fifo_empty[i] && !bus.read_enb[i])
                        tcnt[i] <= tcnt[i] + 1'b1;
                    else
                        tcnt[i] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_1xn.sv
// Self-checking bench for router_1xn (3 ports, 4-deep FIFOs, timeout 30).
// Table vectors, hand-written corner sequences and random packets vs a queue model.
module tb_router_1xn;
    localparam int DW    = 8;
    localparam int NP    = 3;
    localparam int DEPTH = 4;
    localparam int TO    = 30;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    router_1xn_if #(.DATA_W(DW), .NUM_PORTS(NP)) bus ();

    router_1xn #(
        .DATA_W(DW), .NUM_PORTS(NP),
        .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int nvec = 0;
    int nerr = 0;

    // Reference model: each port is an ordered byte queue;
    // a timeout flush empties it.
    logic [7:0] exp_q [NP][$];
    bit [NP-1:0] rd_mask;
    bit          mon_en = 1'b0;
    int          drop_cnt = 0;
    int          sr_cnt [NP];
    int          vo_cnt [NP];
    int          consumed;

    bit   e, bd;
    int   dd, g, s0, v0;

    typedef struct {
        logic [1:0] a;
        int         len;
        int         npl;
        logic [7:0] pbase;
        bit         badpar;
        bit         exp_err;
        int         exp_drop;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.drop) drop_cnt++;
            for (int i = 0; i < NP; i++) begin
                if (bus.soft_reset[i]) begin
                    sr_cnt[i]++;
                    exp_q[i].delete();
                end
                if (bus.valid_out[i]) begin
                    vo_cnt[i]++;
                    if (exp_q[i].size() == 0)
                        chk($sformatf("spurious_p%0d", i), 32'(bus.valid_out[i]), 0);
                    else
                        chk($sformatf("data_p%0d", i),
                            32'(bus.data_out[i*DW +: DW]), 32'(exp_q[i][0]));
                end else begin
                    chk($sformatf("idle_data_p%0d", i),
                        32'(bus.data_out[i*DW +: DW]), 0);
                end
                bus.read_enb[i] = rd_mask[i] && ($urandom_range(0, 9) < 7);
                if (bus.read_enb[i] && bus.valid_out[i])
                    void'(exp_q[i].pop_front());
            end
        end else begin
            bus.read_enb = '0;
        end
    end

    task automatic send(input logic [1:0] a, input int len, input int npl,
                        input logic [7:0] pbase, input bit badpar,
                        output bit got_err, output int got_drop,
                        output bit busy_in_drop);
        logic [7:0] b [$];
        logic [7:0] par;
        int d0, guard;
        b.push_back({len[5:0], a});
        for (int k = 0; k < npl; k++)
            b.push_back(pbase == 0 ? 8'($urandom) : 8'(pbase * (k + 1)));
        par = 8'h00;
        foreach (b[k]) par ^= b[k];
        b.push_back(badpar ? ~par : par);
        if (int'(a) < NP)
            foreach (b[k]) exp_q[a].push_back(b[k]);
        d0 = drop_cnt;
        busy_in_drop = 1'b0;
        consumed = 0;
        foreach (b[k]) begin
            @(negedge clock);
            bus.pkt_valid = (k != b.size() - 1);
            bus.data_in   = b[k];
            #1;
            if (int'(a) >= NP && bus.busy) busy_in_drop = 1'b1;
            guard = 0;
            while (bus.busy && guard < 200) begin
                @(negedge clock);
                #1;
                guard++;
            end
            if (guard == 200) chk("busy_stuck", 32'(bus.busy), 0);
            @(posedge clock);
            consumed++;
        end
        @(negedge clock);
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        @(negedge clock);
        #1;
        got_err  = bus.error;
        got_drop = drop_cnt - d0;
    endtask

    task automatic drain();
        rd_mask = '1;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 3, 3, 8'h11, 1'b0, 1'b0, 0};
        tbl[1] = '{2'd0, 3, 3, 8'h11, 1'b1, 1'b1, 0};
        tbl[2] = '{2'd3, 2, 2, 8'h21, 1'b0, 1'b0, 1};
        tbl[3] = '{2'd2, 4, 3, 8'h05, 1'b0, 1'b1, 0};
        tbl[4] = '{2'd1, 0, 0, 8'h01, 1'b0, 1'b0, 0};
        tbl[5] = '{2'd2, 5, 6, 8'h13, 1'b0, 1'b1, 0};

        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        rd_mask       = '0;
        for (int i = 0; i < NP; i++) begin
            sr_cnt[i] = 0;
            vo_cnt[i] = 0;
        end

        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_drop", 32'(bus.drop), 0);
        chk("rst_soft_reset", 32'(bus.soft_reset), 0);
        chk("rst_valid_out", 32'(bus.valid_out), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        rd_mask = '1;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].a, tbl[i].len, tbl[i].npl, tbl[i].pbase,
                 tbl[i].badpar, e, dd, bd);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_drop", i), 32'(dd), 32'(tbl[i].exp_drop));
            if (tbl[i].exp_drop != 0)
                chk($sformatf("tbl%0d_drop_busy", i), 32'(bd), 0);
        end

        // Error holds while idle and clears at the next header edge.
        drain();
        send(2'd0, 1, 1, 8'h61, 1'b1, e, dd, bd);
        chk("hold_err_set", 32'(e), 1);
        repeat (12) @(negedge clock);
        #1;
        chk("hold_err_idle", 32'(bus.error), 1);
        exp_q[0].push_back(8'h00);
        exp_q[0].push_back(8'h00);
        @(negedge clock);
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'h00;
        @(posedge clock);
        #1;
        chk("err_clear_at_hdr", 32'(bus.error), 0);
        @(negedge clock);
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        #1;
        g = 0;
        while (bus.busy && g < 50) begin
            @(negedge clock);
            #1;
            g++;
        end
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("err_after_good", 32'(bus.error), 0);

        // Backpressure: 4-deep FIFO on port 1 with no reads.
        drain();
        rd_mask = 3'b101;
        fork
            send(2'd1, 8, 8, 8'h31, 1'b0, e, dd, bd);
            begin
                g = 0;
                @(negedge clock);
                #1;
                while (!bus.busy && g < 40) begin
                    @(negedge clock);
                    #1;
                    g++;
                end
                chk("bp_busy", 32'(bus.busy), 1);
                chk("bp_written", 32'(consumed), 4);
                repeat (10) @(negedge clock);
                rd_mask[1] = 1'b1;
            end
        join
        chk("bp_err", 32'(e), 0);
        drain();
        chk("bp_drained", 32'(exp_q[1].size()), 0);

        // Timeout with a complete packet parked on port 2.
        rd_mask = 3'b011;
        s0 = sr_cnt[2];
        v0 = vo_cnt[2];
        send(2'd2, 1, 1, 8'h41, 1'b0, e, dd, bd);
        chk("to_err", 32'(e), 0);
        g = 0;
        while (sr_cnt[2] == s0 && g < 60) begin
            @(negedge clock);
            #1;
            g++;
        end
        chk("to_pulse", 32'(sr_cnt[2] - s0), 1);
        chk("to_stall_cycles", 32'(vo_cnt[2] - v0), TO);
        chk("to_valid", 32'(bus.valid_out[2]), 0);
        repeat (5) @(negedge clock);
        #1;
        chk("to_once", 32'(sr_cnt[2] - s0), 1);

        // Timeout while the packet is still arriving.
        s0 = sr_cnt[2];
        v0 = vo_cnt[2];
        send(2'd2, 8, 8, 8'h51, 1'b0, e, dd, bd);
        chk("tom_pulse", 32'(sr_cnt[2] - s0), 1);
        chk("tom_stall_cycles", 32'(vo_cnt[2] - v0), TO);
        chk("tom_err", 32'(e), 0);
        chk("tom_valid", 32'(bus.valid_out[2]), 0);
        chk("tom_busy", 32'(bus.busy), 0);
        rd_mask = '1;
        send(2'd2, 2, 2, 8'h07, 1'b0, e, dd, bd);
        chk("tom_next_err", 32'(e), 0);

        // Reset in the middle of a packet.
        drain();
        mon_en = 1'b0;
        @(negedge clock);
        bus.pkt_valid = 1'b1;
        bus.data_in   = {6'd5, 2'd0};
        @(negedge clock);
        bus.data_in   = 8'h55;
        @(negedge clock);
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.valid_out), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_error", 32'(bus.error), 0);
        for (int i = 0; i < NP; i++) exp_q[i].delete();
        mon_en = 1'b1;
        send(2'd0, 2, 2, 8'h09, 1'b0, e, dd, bd);
        chk("mid_rst_next_err", 32'(e), 0);

        // Random packets against the queue model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] a;
            int len, npl;
            bit bp;
            a   = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 10);
            npl = len;
            if ($urandom_range(0, 5) == 0)
                npl = len + 1;
            else if ($urandom_range(0, 5) == 0 && len > 0)
                npl = len - 1;
            bp = ($urandom_range(0, 5) == 0);
            send(a, len, npl, 8'h00, bp, e, dd, bd);
            chk($sformatf("rnd%0d_err", n), 32'(e),
                32'(int'(a) < NP && (bp || npl != len)));
            chk($sformatf("rnd%0d_drop", n), 32'(dd), 32'(int'(a) >= NP));
            if (int'(a) >= NP)
                chk($sformatf("rnd%0d_drop_busy", n), 32'(bd), 0);
        end

        drain();
        repeat (10) @(negedge clock);
        #1;
        for (int i = 0; i < NP; i++)
            chk($sformatf("final_q%0d", i), 32'(exp_q[i].size()), 0);
        chk("final_valid", 32'(bus.valid_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
